// File: rtl/md_unit_pkg.sv
// Shared MD-unit definitions: operation encodings, default latencies and the
// combinational multiply/divide kernel used at operation start.
package md_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
    } md_res_t;

    function automatic md_res_t md_compute(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        md_res_t     r;
        logic [63:0] sa, sb;
        logic [31:0] ma, mb, q, rm;
        r    = '0;
        r.we = 1'b1;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ma   = a[31] ? -a : a;
        mb   = b[31] ? -b : b;
        q    = '0;
        rm   = '0;
        case (op)
            MD_MULT:  {r.hi, r.lo} = sa * sb;
            MD_MULTU: {r.hi, r.lo} = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                // Divide magnitudes then restore signs; this also makes
                // 0x80000000 / -1 come out as 0x80000000 remainder 0.
                if (b == 32'd0) begin
                    r.we = 1'b0;
                end else begin
                    q    = ma / mb;
                    rm   = ma % mb;
                    r.lo = (a[31] ^ b[31]) ? -q : q;
                    r.hi = a[31] ? -rm : rm;
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    r.we = 1'b0;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r.we = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX-stage issue logic and the MD unit.
interface md_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDOp, start, input  busy, HI, LO);
    modport slave  (input  A, B, MDOp, start, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning architectural HI/LO; the result is
// computed at start and held in pending registers until the latency expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_res_t     w_res;
    logic        w_is_md;
    logic        w_is_div;

    assign w_res    = md_compute(bus.MDOp, bus.A, bus.B);
    assign w_is_md  = (bus.MDOp <= MD_DIVU);
    assign w_is_div = (bus.MDOp == MD_DIV) || (bus.MDOp == MD_DIVU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_is_md) begin
                            r_pend_hi <= w_res.hi;
                            r_pend_lo <= w_res.lo;
                            r_pend_we <= w_res.we;
                            r_cnt     <= w_is_div ? DIV_LOAD : MULT_LOAD;
                            r_state   <= ST_RUN;
                        end else if (bus.MDOp == MD_MTHI) begin
                            r_hi <= bus.A;
                        end else if (bus.MDOp == MD_MTLO) begin
                            r_lo <= bus.A;
                        end
                    end
                end
                default: begin
                    // Any start seen here is dropped; hazard logic never issues one.
                    if (r_cnt == 4'd0) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_state[0];
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corners, MTHI/MTLO, mid-run
// operand changes and asynchronous reset abort.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one MD op, count busy cycles (bounded), confirm HI/LO are held
    // while busy; optionally pulse a stray start with new operands mid-run.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input int pulse_at);
        logic [31:0] hi0, lo0;
        int          cnt;
        logic        held_ok;
        hi0 = bus.HI;
        lo0 = bus.LO;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = 32'hDEADBEEF; bus.B = 32'h0;
        cnt = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held_ok = 1'b0;
            if (pulse_at != 0 && cnt == pulse_at) begin
                bus.start = 1'b1; bus.MDOp = MD_MULT; bus.A = 32'd3; bus.B = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({tag, ".cycles"}, 32'(cnt), 32'(n));
        check({tag, ".held"}, {31'd0, held_ok}, 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.MDOp = 3'd0; bus.A = '0; bus.B = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.hi", bus.HI, 32'h0);
        check("rst.lo", bus.LO, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 0);
        check("mult.hi", bus.HI, 32'hFFFFFFFF);
        check("mult.lo", bus.LO, 32'hFFFFFFFA);

        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 0);
        check("multu.hi", bus.HI, 32'h00000001);
        check("multu.lo", bus.LO, 32'hFFFFFFFE);

        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 0);
        check("div.lo", bus.LO, 32'hFFFFFFFD);
        check("div.hi", bus.HI, 32'hFFFFFFFF);

        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 0);
        check("divu0.lo", bus.LO, 32'hFFFFFFFD);
        check("divu0.hi", bus.HI, 32'hFFFFFFFF);

        run_op("divneg", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 0);
        check("divneg.lo", bus.LO, 32'hFFFFFFFD);
        check("divneg.hi", bus.HI, 32'h00000001);

        run_op("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 0);
        check("divovf.lo", bus.LO, 32'h80000000);
        check("divovf.hi", bus.HI, 32'h00000000);

        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 0);
        check("divu.lo", bus.LO, 32'd14);
        check("divu.hi", bus.HI, 32'd2);

        // MTHI then MTLO on consecutive edges
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MDOp = MD_MTHI; bus.A = 32'h12345678;
        @(posedge clk); #1;
        bus.MDOp = MD_MTLO; bus.A = 32'h9ABCDEF0;
        @(negedge clk);
        check("mthi.hi", bus.HI, 32'h12345678);
        check("mthi.lo", bus.LO, 32'd14);
        check("mthi.busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mtlo.lo", bus.LO, 32'h9ABCDEF0);
        check("mtlo.hi", bus.HI, 32'h12345678);
        check("mtlo.busy", {31'd0, bus.busy}, 32'd0);

        // Reserved op is a no-op
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MDOp = 3'd6; bus.A = 32'h55555555;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("rsv.busy", {31'd0, bus.busy}, 32'd0);
        check("rsv.hi", bus.HI, 32'h12345678);
        check("rsv.lo", bus.LO, 32'h9ABCDEF0);

        // Operands changed and stray start mid-run
        run_op("midrun", MD_DIV, 32'd100, 32'd7, 10, 3);
        check("midrun.lo", bus.LO, 32'd14);
        check("midrun.hi", bus.HI, 32'd2);
        @(negedge clk);
        check("midrun.idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the 4th busy cycle of a DIV
        @(posedge clk); #1;
        bus.start = 1'b1; bus.MDOp = MD_DIV; bus.A = 32'd50; bus.B = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("arst.pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst.busy", {31'd0, bus.busy}, 32'd0);
        check("arst.hi", bus.HI, 32'h0);
        check("arst.lo", bus.LO, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("arst.late.busy", {31'd0, bus.busy}, 32'd0);
        check("arst.late.hi", bus.HI, 32'h0);
        check("arst.late.lo", bus.LO, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
